// File: rtl/id_operand_fetch_pkg.sv
// ---------------------------------------------------------------------------
// id_operand_fetch_pkg
//
// Shared constants and types for the decode-stage operand fetch slice.
//   XLEN     : operand / writeback data width
//   NREGS    : number of architectural registers
//   AW       : register address width
//   REG_ZERO : index of the hard-wired zero register
//   reg_addr_t, xword_t : address and data word types
//   select_operand()    : zero / writeback-bypass / register-file operand mux
// ---------------------------------------------------------------------------
package id_operand_fetch_pkg;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int AW    = 5;

  typedef logic [AW-1:0]   reg_addr_t;
  typedef logic [XLEN-1:0] xword_t;

  localparam reg_addr_t REG_ZERO = '0;

  // x0 always reads as zero. A writeback landing this cycle must be
  // forwarded, because the register file writes on the falling edge and its
  // read data does not re-evaluate when the stored value changes.
  function automatic xword_t select_operand(
    input reg_addr_t rs,
    input logic      wb_valid,
    input reg_addr_t wb_rd,
    input xword_t    wb_data,
    input xword_t    rf_data
  );
    xword_t result;
    if (rs == REG_ZERO) begin
      result = '0;
    end else if (wb_valid && (wb_rd == rs)) begin
      result = wb_data;
    end else begin
      result = rf_data;
    end
    return result;
  endfunction

endpackage

// File: rtl/id_operand_fetch_if.sv
// ---------------------------------------------------------------------------
// id_operand_fetch_if
//
// Bundles every bus of the operand fetch stage:
//   decode side   : in_valid/in_ready, in_rs1, in_rs2, in_rd, in_rd_wen
//   regfile reads : readregA/readregB out, readdataA/readdataB in
//   writeback     : wb_valid, wb_rd, wb_data in; writereg, writedata,
//                   RegWrite out to the register file
//   EX side       : flush, out_valid/out_ready, out_rs1_data, out_rs2_data,
//                   out_rd, out_rd_wen
// Modports:
//   master : the operand fetch stage itself
//   slave  : the surrounding pipeline / register file / testbench
// ---------------------------------------------------------------------------
interface id_operand_fetch_if;
  import id_operand_fetch_pkg::*;

  logic      in_valid;
  logic      in_ready;
  reg_addr_t in_rs1;
  reg_addr_t in_rs2;
  reg_addr_t in_rd;
  logic      in_rd_wen;

  reg_addr_t readregA;
  reg_addr_t readregB;
  xword_t    readdataA;
  xword_t    readdataB;

  logic      wb_valid;
  reg_addr_t wb_rd;
  xword_t    wb_data;
  reg_addr_t writereg;
  xword_t    writedata;
  logic      RegWrite;

  logic      flush;
  logic      out_valid;
  logic      out_ready;
  xword_t    out_rs1_data;
  xword_t    out_rs2_data;
  reg_addr_t out_rd;
  logic      out_rd_wen;

  modport master (
    input  in_valid, in_rs1, in_rs2, in_rd, in_rd_wen,
    output in_ready,
    output readregA, readregB,
    input  readdataA, readdataB,
    input  wb_valid, wb_rd, wb_data,
    output writereg, writedata, RegWrite,
    input  flush, out_ready,
    output out_valid, out_rs1_data, out_rs2_data, out_rd, out_rd_wen
  );

  modport slave (
    output in_valid, in_rs1, in_rs2, in_rd, in_rd_wen,
    input  in_ready,
    input  readregA, readregB,
    output readdataA, readdataB,
    output wb_valid, wb_rd, wb_data,
    input  writereg, writedata, RegWrite,
    output flush, out_ready,
    input  out_valid, out_rs1_data, out_rs2_data, out_rd, out_rd_wen
  );

endinterface

// File: rtl/id_operand_fetch_scoreboard.sv
// ---------------------------------------------------------------------------
// opf_scoreboard
//
// One pending bit per architectural register, marking registers that have
// an issued writer whose result has not yet come back on writeback.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   wb_valid, wb_rd   : writeback clears the bit and hides it from busy()
//   kill_en, kill_idx : clear for an instruction killed in the output register
//   set_en, set_idx   : newly issued writer
//   q_rs1/q_rs2/q_rd  : three busy() lookups
//   busy_rs1/2/rd     : lookup results (x0 never busy)
// ---------------------------------------------------------------------------
module opf_scoreboard
  import id_operand_fetch_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      wb_valid,
  input  reg_addr_t wb_rd,
  input  logic      kill_en,
  input  reg_addr_t kill_idx,
  input  logic      set_en,
  input  reg_addr_t set_idx,
  input  reg_addr_t q_rs1,
  input  reg_addr_t q_rs2,
  input  reg_addr_t q_rd,
  output logic      busy_rs1,
  output logic      busy_rs2,
  output logic      busy_rd
);

  logic [NREGS-1:0] sb_q;
  logic [NREGS-1:0] sb_d;

  // A register whose writeback arrives this cycle is no longer busy: its
  // value is available through the bypass path.
  function automatic logic is_busy(input logic [NREGS-1:0] sb, input reg_addr_t r,
                                   input logic wv, input reg_addr_t wr);
    return (r != REG_ZERO) && sb[r] && !(wv && (wr == r));
  endfunction

  always_comb begin
    busy_rs1 = is_busy(sb_q, q_rs1, wb_valid, wb_rd);
    busy_rs2 = is_busy(sb_q, q_rs2, wb_valid, wb_rd);
    busy_rd  = is_busy(sb_q, q_rd,  wb_valid, wb_rd);
  end

  // Clears first, then the set, so a new writer wins over a same-cycle
  // clear of the same register.
  always_comb begin
    sb_d = sb_q;
    if (wb_valid) begin
      sb_d[wb_rd] = 1'b0;
    end
    if (kill_en) begin
      sb_d[kill_idx] = 1'b0;
    end
    if (set_en) begin
      sb_d[set_idx] = 1'b1;
    end
    sb_d[REG_ZERO] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sb_q <= '0;
    end else begin
      sb_q <= sb_d;
    end
  end

endmodule

// File: rtl/id_operand_fetch.sv
// ---------------------------------------------------------------------------
// id_operand_fetch
//
// Decode-stage operand fetch for a 2-read/1-write register file. Drives the
// read addresses, bypasses same-cycle writeback data, stalls on RAW/WAW
// hazards using a pending-register scoreboard, and presents operands to EX
// through a 1-entry valid/ready output register. Also forwards the
// writeback bus to the register-file write port.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   bus       : id_operand_fetch_if.master (decode, regfile, writeback, EX)
//   stall_cnt : 32-bit saturating count of cycles with in_valid && hazard,
//               present only when OPFETCH_STALL_CNT_EN is defined
// ---------------------------------------------------------------------------
module id_operand_fetch
  import id_operand_fetch_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  id_operand_fetch_if.master bus
`ifdef OPFETCH_STALL_CNT_EN
  ,
  output logic [31:0]        stall_cnt
`endif
);

  logic      busy_rs1;
  logic      busy_rs2;
  logic      busy_rd;
  logic      hazard;
  logic      in_ready;
  logic      issue;
  logic      sb_set_en;
  logic      sb_kill_en;
  xword_t    op1;
  xword_t    op2;

  logic      out_valid_q,    out_valid_d;
  xword_t    out_rs1_data_q, out_rs1_data_d;
  xword_t    out_rs2_data_q, out_rs2_data_d;
  reg_addr_t out_rd_q,       out_rd_d;
  logic      out_rd_wen_q,   out_rd_wen_d;

  assign bus.readregA  = bus.in_rs1;
  assign bus.readregB  = bus.in_rs2;
  assign bus.writereg  = bus.wb_rd;
  assign bus.writedata = bus.wb_data;
  assign bus.RegWrite  = bus.wb_valid && (bus.wb_rd != REG_ZERO);

  opf_scoreboard u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .wb_valid (bus.wb_valid),
    .wb_rd    (bus.wb_rd),
    .kill_en  (sb_kill_en),
    .kill_idx (out_rd_q),
    .set_en   (sb_set_en),
    .set_idx  (bus.in_rd),
    .q_rs1    (bus.in_rs1),
    .q_rs2    (bus.in_rs2),
    .q_rd     (bus.in_rd),
    .busy_rs1 (busy_rs1),
    .busy_rs2 (busy_rs2),
    .busy_rd  (busy_rd)
  );

  // Hazard detection and handshake. The WAW term keeps at most one
  // outstanding writer per register, so one pending bit is enough.
  always_comb begin
    hazard     = busy_rs1 || busy_rs2 || (bus.in_rd_wen && busy_rd);
    in_ready   = (!out_valid_q || bus.out_ready) && !hazard && !bus.flush;
    issue      = bus.in_valid && in_ready;
    sb_set_en  = issue && bus.in_rd_wen && (bus.in_rd != REG_ZERO);
    sb_kill_en = bus.flush && out_valid_q && out_rd_wen_q;
    op1 = select_operand(bus.in_rs1, bus.wb_valid, bus.wb_rd, bus.wb_data, bus.readdataA);
    op2 = select_operand(bus.in_rs2, bus.wb_valid, bus.wb_rd, bus.wb_data, bus.readdataB);
  end

  // Output register: flush kills the held entry, an issue loads a new one,
  // and otherwise a consumed entry drains. Fields hold under backpressure.
  always_comb begin
    out_valid_d    = out_valid_q;
    out_rs1_data_d = out_rs1_data_q;
    out_rs2_data_d = out_rs2_data_q;
    out_rd_d       = out_rd_q;
    out_rd_wen_d   = out_rd_wen_q;
    if (bus.flush) begin
      out_valid_d = 1'b0;
    end else if (issue) begin
      out_valid_d    = 1'b1;
      out_rs1_data_d = op1;
      out_rs2_data_d = op2;
      out_rd_d       = bus.in_rd;
      out_rd_wen_d   = bus.in_rd_wen;
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q    <= 1'b0;
      out_rs1_data_q <= '0;
      out_rs2_data_q <= '0;
      out_rd_q       <= '0;
      out_rd_wen_q   <= 1'b0;
    end else begin
      out_valid_q    <= out_valid_d;
      out_rs1_data_q <= out_rs1_data_d;
      out_rs2_data_q <= out_rs2_data_d;
      out_rd_q       <= out_rd_d;
      out_rd_wen_q   <= out_rd_wen_d;
    end
  end

  assign bus.in_ready     = in_ready;
  assign bus.out_valid    = out_valid_q;
  assign bus.out_rs1_data = out_rs1_data_q;
  assign bus.out_rs2_data = out_rs2_data_q;
  assign bus.out_rd       = out_rd_q;
  assign bus.out_rd_wen   = out_rd_wen_q;

`ifdef OPFETCH_STALL_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  // Saturating count of cycles where a valid instruction waits on a hazard.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (bus.in_valid && hazard && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_id_operand_fetch.sv
// ---------------------------------------------------------------------------
// tb_id_operand_fetch
//
// Directed testbench for id_operand_fetch. Inputs change 1 time unit after
// the rising edge; outputs are sampled a further unit later.
// ---------------------------------------------------------------------------
module tb_id_operand_fetch;
  import id_operand_fetch_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  id_operand_fetch_if bus ();

`ifdef OPFETCH_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  id_operand_fetch dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef OPFETCH_STALL_CNT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.in_valid  = 1'b0;
    bus.in_rs1    = '0;
    bus.in_rs2    = '0;
    bus.in_rd     = '0;
    bus.in_rd_wen = 1'b0;
    bus.readdataA = '0;
    bus.readdataB = '0;
    bus.wb_valid  = 1'b0;
    bus.wb_rd     = '0;
    bus.wb_data   = '0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b1;
  endtask

  task automatic drive_instr(input reg_addr_t rs1, input reg_addr_t rs2,
                             input reg_addr_t rd, input logic wen);
    bus.in_valid  = 1'b1;
    bus.in_rs1    = rs1;
    bus.in_rs2    = rs2;
    bus.in_rd     = rd;
    bus.in_rd_wen = wen;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_out_valid act=%0h exp=0", bus.out_valid); end
    checks++; if (bus.out_rs1_data !== 32'h0) begin failures++; $display("[TB] FAIL reset_rs1_data act=%0h exp=0", bus.out_rs1_data); end
    checks++; if (bus.out_rs2_data !== 32'h0) begin failures++; $display("[TB] FAIL reset_rs2_data act=%0h exp=0", bus.out_rs2_data); end
    checks++; if (bus.out_rd !== 5'd0 || bus.out_rd_wen !== 1'b0) begin failures++; $display("[TB] FAIL reset_rd act=%0h/%0h exp=0/0", bus.out_rd, bus.out_rd_wen); end
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_in_ready act=%0h exp=1", bus.in_ready); end
  endtask

  task automatic test_zero_operand();
    bus.readdataA = 32'hDEAD;
    bus.readdataB = 32'h55;
    drive_instr(5'd0, 5'd3, 5'd2, 1'b0);
    #1;
    checks++; if (bus.readregB !== 5'd3) begin failures++; $display("[TB] FAIL zero_readregB act=%0h exp=3", bus.readregB); end
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("[TB] FAIL zero_in_ready act=%0h exp=1", bus.in_ready); end
    tick();
    bus.in_valid = 1'b0;
    checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("[TB] FAIL zero_out_valid act=%0h exp=1", bus.out_valid); end
    checks++; if (bus.out_rs1_data !== 32'h0) begin failures++; $display("[TB] FAIL zero_rs1_data act=%0h exp=0", bus.out_rs1_data); end
    checks++; if (bus.out_rs2_data !== 32'h55) begin failures++; $display("[TB] FAIL zero_rs2_data act=%0h exp=55", bus.out_rs2_data); end
    checks++; if (bus.out_rd !== 5'd2) begin failures++; $display("[TB] FAIL zero_out_rd act=%0h exp=2", bus.out_rd); end
    tick();
    idle();
  endtask

  task automatic test_raw_bypass();
    drive_instr(5'd0, 5'd0, 5'd5, 1'b1);
    tick();
    checks++; if (bus.out_rd !== 5'd5 || bus.out_rd_wen !== 1'b1) begin failures++; $display("[TB] FAIL raw_out_rd act=%0h/%0h exp=5/1", bus.out_rd, bus.out_rd_wen); end
    bus.readdataA = 32'hBAD;
    drive_instr(5'd5, 5'd0, 5'd0, 1'b0);
    #1;
    checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("[TB] FAIL raw_stall0 act=%0h exp=0", bus.in_ready); end
    tick();
    checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("[TB] FAIL raw_stall1 act=%0h exp=0", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("[TB] FAIL raw_drained act=%0h exp=0", bus.out_valid); end
    bus.wb_valid = 1'b1;
    bus.wb_rd    = 5'd5;
    bus.wb_data  = 32'h1234;
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("[TB] FAIL raw_wb_ready act=%0h exp=1", bus.in_ready); end
    checks++; if (bus.RegWrite !== 1'b1 || bus.writereg !== 5'd5 || bus.writedata !== 32'h1234) begin failures++; $display("[TB] FAIL raw_wr_port act=%0h/%0h/%0h exp=1/5/1234", bus.RegWrite, bus.writereg, bus.writedata); end
    tick();
    bus.wb_valid = 1'b0;
    bus.in_valid = 1'b0;
    checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("[TB] FAIL raw_issue_valid act=%0h exp=1", bus.out_valid); end
    checks++; if (bus.out_rs1_data !== 32'h1234) begin failures++; $display("[TB] FAIL raw_bypass act=%0h exp=1234", bus.out_rs1_data); end
    bus.readdataA = 32'h4321;
    drive_instr(5'd5, 5'd0, 5'd0, 1'b0);
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("[TB] FAIL raw_cleared act=%0h exp=1", bus.in_ready); end
    tick();
    bus.in_valid = 1'b0;
    checks++; if (bus.out_rs1_data !== 32'h4321) begin failures++; $display("[TB] FAIL raw_rf_data act=%0h exp=4321", bus.out_rs1_data); end
    tick();
    idle();
  endtask

  task automatic test_same_cycle_set_clear();
    drive_instr(5'd0, 5'd0, 5'd7, 1'b1);
    tick();
    bus.wb_valid = 1'b1;
    bus.wb_rd    = 5'd7;
    bus.wb_data  = 32'h7;
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("[TB] FAIL setclr_ready act=%0h exp=1", bus.in_ready); end
    tick();
    bus.wb_valid = 1'b0;
    drive_instr(5'd7, 5'd0, 5'd0, 1'b0);
    #1;
    checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("[TB] FAIL setclr_pending act=%0h exp=0", bus.in_ready); end
    bus.in_valid = 1'b0;
    bus.wb_valid = 1'b1;
    bus.wb_rd    = 5'd7;
    tick();
    bus.wb_valid = 1'b0;
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("[TB] FAIL setclr_cleared act=%0h exp=1", bus.in_ready); end
    idle();
  endtask

  task automatic test_backpressure();
    bus.out_ready = 1'b0;
    bus.readdataB = 32'h77;
    drive_instr(5'd0, 5'd3, 5'd10, 1'b0);
    tick();
    bus.readdataB = 32'h88;
    drive_instr(5'd0, 5'd4, 5'd11, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("[TB] FAIL bp_ready[%0d] act=%0h exp=0", i, bus.in_ready); end
      checks++; if (bus.out_valid !== 1'b1 || bus.out_rs2_data !== 32'h77 || bus.out_rd !== 5'd10) begin failures++; $display("[TB] FAIL bp_hold[%0d] act=%0h/%0h/%0h exp=1/77/a", i, bus.out_valid, bus.out_rs2_data, bus.out_rd); end
      tick();
    end
    bus.out_ready = 1'b1;
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("[TB] FAIL bp_release act=%0h exp=1", bus.in_ready); end
    tick();
    bus.in_valid = 1'b0;
    checks++; if (bus.out_valid !== 1'b1 || bus.out_rs2_data !== 32'h88 || bus.out_rd !== 5'd11) begin failures++; $display("[TB] FAIL bp_next act=%0h/%0h/%0h exp=1/88/b", bus.out_valid, bus.out_rs2_data, bus.out_rd); end
    tick();
    idle();
  endtask

  task automatic test_flush();
    bus.out_ready = 1'b0;
    drive_instr(5'd0, 5'd0, 5'd9, 1'b1);
    tick();
    bus.in_valid = 1'b0;
    checks++; if (bus.out_valid !== 1'b1 || bus.out_rd !== 5'd9) begin failures++; $display("[TB] FAIL flush_held act=%0h/%0h exp=1/9", bus.out_valid, bus.out_rd); end
    bus.flush = 1'b1;
    #1;
    checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("[TB] FAIL flush_blocks act=%0h exp=0", bus.in_ready); end
    tick();
    bus.flush = 1'b0;
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("[TB] FAIL flush_killed act=%0h exp=0", bus.out_valid); end
    bus.readdataA = 32'h99;
    drive_instr(5'd9, 5'd0, 5'd0, 1'b0);
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("[TB] FAIL flush_sb_clear act=%0h exp=1", bus.in_ready); end
    tick();
    bus.in_valid = 1'b0;
    checks++; if (bus.out_valid !== 1'b1 || bus.out_rs1_data !== 32'h99) begin failures++; $display("[TB] FAIL flush_reissue act=%0h/%0h exp=1/99", bus.out_valid, bus.out_rs1_data); end
    bus.out_ready = 1'b1;
    tick();
    idle();
  endtask

  task automatic test_wb_x0();
    bus.wb_valid  = 1'b1;
    bus.wb_rd     = 5'd0;
    bus.wb_data   = 32'hFF;
    bus.readdataA = 32'h123;
    drive_instr(5'd0, 5'd0, 5'd0, 1'b0);
    #1;
    checks++; if (bus.RegWrite !== 1'b0) begin failures++; $display("[TB] FAIL x0_regwrite act=%0h exp=0", bus.RegWrite); end
    checks++; if (bus.writedata !== 32'hFF) begin failures++; $display("[TB] FAIL x0_writedata act=%0h exp=ff", bus.writedata); end
    tick();
    bus.in_valid = 1'b0;
    checks++; if (bus.out_rs1_data !== 32'h0) begin failures++; $display("[TB] FAIL x0_operand act=%0h exp=0", bus.out_rs1_data); end
    bus.wb_rd   = 5'd12;
    bus.wb_data = 32'hC;
    #1;
    checks++; if (bus.RegWrite !== 1'b1 || bus.writereg !== 5'd12) begin failures++; $display("[TB] FAIL np_regwrite act=%0h/%0h exp=1/c", bus.RegWrite, bus.writereg); end
    tick();
    bus.wb_valid  = 1'b0;
    bus.readdataA = 32'hC;
    drive_instr(5'd12, 5'd0, 5'd0, 1'b0);
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("[TB] FAIL np_no_pending act=%0h exp=1", bus.in_ready); end
    tick();
    idle();
    tick();
  endtask

  task automatic test_reset_mid();
    drive_instr(5'd0, 5'd0, 5'd14, 1'b1);
    tick();
    bus.in_valid = 1'b0;
    rst          = 1'b1;
    bus.wb_valid = 1'b1;
    bus.wb_rd    = 5'd20;
    bus.wb_data  = 32'hAB;
    #1;
    checks++; if (bus.RegWrite !== 1'b1 || bus.writereg !== 5'd20 || bus.writedata !== 32'hAB) begin failures++; $display("[TB] FAIL rstmid_wb act=%0h/%0h/%0h exp=1/14/ab", bus.RegWrite, bus.writereg, bus.writedata); end
    tick();
    rst          = 1'b0;
    bus.wb_valid = 1'b0;
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("[TB] FAIL rstmid_valid act=%0h exp=0", bus.out_valid); end
    drive_instr(5'd14, 5'd0, 5'd0, 1'b0);
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("[TB] FAIL rstmid_sb act=%0h exp=1", bus.in_ready); end
    tick();
    idle();
    tick();
  endtask

`ifdef OPFETCH_STALL_CNT_EN
  task automatic test_stall_cnt();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (stall_cnt !== 32'd0) begin failures++; $display("[TB] FAIL stall_cnt_reset act=%0h exp=0", stall_cnt); end
    drive_instr(5'd0, 5'd0, 5'd13, 1'b1);
    tick();
    drive_instr(5'd13, 5'd0, 5'd0, 1'b0);
    repeat (4) tick();
    bus.in_valid = 1'b0;
    checks++; if (stall_cnt !== 32'd4) begin failures++; $display("[TB] FAIL stall_cnt_4 act=%0h exp=4", stall_cnt); end
    bus.wb_valid = 1'b1;
    bus.wb_rd    = 5'd13;
    tick();
    idle();
    tick();
    checks++; if (stall_cnt !== 32'd4) begin failures++; $display("[TB] FAIL stall_cnt_hold act=%0h exp=4", stall_cnt); end
  endtask
`endif

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    idle();
    test_reset();
    test_zero_operand();
    test_raw_bypass();
    test_same_cycle_set_clear();
    test_backpressure();
    test_flush();
    test_wb_x0();
    test_reset_mid();
`ifdef OPFETCH_STALL_CNT_EN
    test_stall_cnt();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/id_operand_fetch.md
Name: id_operand_fetch

Overview:
- Decode-stage initiator for the 2-read/1-write register file.
- Drives the read addresses and captures the returned operand data. Drives the write port from the writeback bus.
- Tracks in-flight destination registers in a scoreboard and stalls on RAW/WAW hazards. Bypasses same-cycle writeback data.
- Presents operands to EX through a 1-entry valid/ready pipeline register.

Parameters:
- XLEN, 32, data width of operands and writeback data
- NREGS, 32, number of architectural registers
- AW, 5, register address width (log2 NREGS)

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  decoded instruction available
- in_ready  out  1  instruction accepted this cycle when in_valid && in_ready
- in_rs1  in  AW  source register 1
- in_rs2  in  AW  source register 2
- in_rd  in  AW  destination register
- in_rd_wen  in  1  instruction writes in_rd
- readregA  out  AW  register-file read address A (= in_rs1, combinational)
- readregB  out  AW  register-file read address B (= in_rs2, combinational)
- readdataA  in  XLEN  register-file read data A
- readdataB  in  XLEN  register-file read data B
- wb_valid  in  1  writeback result valid
- wb_rd  in  AW  writeback destination
- wb_data  in  XLEN  writeback data
- writereg  out  AW  register-file write address (= wb_rd)
- writedata  out  XLEN  register-file write data (= wb_data)
- RegWrite  out  1  wb_valid && wb_rd != 0
- flush  in  1  kill the instruction held in the output register
- out_valid  out  1  operands valid toward EX
- out_ready  in  1  EX accepts
- out_rs1_data  out  XLEN  operand 1
- out_rs2_data  out  XLEN  operand 2
- out_rd  out  AW  destination
- out_rd_wen  out  1  destination write enable

Behaviour:
- Clock and reset: clk, rst; single clock; reset is synchronous, active-high.
- Reset values:
  - out_valid = 0; out_rs1_data, out_rs2_data, out_rd, out_rd_wen = 0
  - scoreboard[NREGS-1:0] = 0
- Pending bit: busy(r) = scoreboard[r] && !(wb_valid && wb_rd == r). x0 is never busy.
- Hazard:
  - hazard = (busy(in_rs1) && in_rs1 != 0) || (busy(in_rs2) && in_rs2 != 0) || (in_rd_wen && busy(in_rd))
  - WAW stalling guarantees at most one outstanding writer per register.
- Handshake:
  - in_ready = (!out_valid || out_ready) && !hazard && !flush
  - Issue = in_valid && in_ready. Latency from issue to out_valid is 1 cycle.
- Operand select, priority order:
  1. rs == 0 -> 0, regardless of register-file contents.
  2. wb_valid && wb_rd == rs -> wb_data. Bypass is required because the register file writes on the falling edge and does not re-evaluate reads on data change.
  3. Otherwise readdataA/readdataB.
- Scoreboard update per cycle:
  - Clear bit wb_rd on wb_valid.
  - Clear bit out_rd when flush && out_valid && out_rd_wen.
  - Set bit in_rd on issue with in_rd_wen && in_rd != 0. Set wins over a same-cycle clear of the same index.
- Output register:
  - flush: out_valid <= 0.
  - Else on issue: load fields, out_valid <= 1.
  - Else if out_ready: out_valid <= 0.
  - Fields hold while out_valid && !out_ready.
- Boundaries:
  - wb to x0: RegWrite = 0, no scoreboard change.
  - wb to a register that is not pending: write performed, bit stays 0.
  - Reset mid-operation: all pending bits dropped. In-flight writebacks still pass to the register file.

Optional Feature:
- Macro: OPFETCH_STALL_CNT_EN.
- Defined:
  - Adds output port stall_cnt, 32 bits, reset 0.
  - Increments on each cycle with in_valid && hazard. Saturates at 0xFFFFFFFF.
- Undefined: port and counter absent; behaviour otherwise identical.

Decomposition:
- Shared package: XLEN, NREGS, AW constants; REG_ZERO = 0; typedef reg_addr_t [AW-1:0]; typedef xword_t [XLEN-1:0].
- One natural sub-module: opf_scoreboard, holding the set/clear vector and the busy() lookup for 3 ports.
- Bypass mux and pipeline register stay in the top module.

Test Plan:
1. Reset, readdataA = 0xDEAD, issue rs1 = 0, rs2 = 3 (readdataB = 0x55) -> next cycle out_rs1_data = 0, out_rs2_data = 0x55, out_valid = 1.
2. Issue rd = 5 wen -> scoreboard[5] = 1. Then rs1 = 5 stalls (in_ready = 0) until wb_valid, wb_rd = 5, wb_data = 0x1234. That cycle the instruction issues with out_rs1_data = 0x1234 (bypass).
3. Same-cycle wb_rd = 7 clear and issue with in_rd = 7 wen -> scoreboard[7] = 1 afterwards.
4. out_ready = 0 for 3 cycles with out_valid = 1 -> in_ready = 0, output fields unchanged. out_ready = 1 -> next instruction loads.
5. Output holds rd = 9 wen, assert flush -> out_valid = 0, scoreboard[9] = 0. An instruction reading x9 then issues without stall.
6. wb_valid, wb_rd = 0, wb_data = 0xFF -> RegWrite = 0. With OPFETCH_STALL_CNT_EN, 4 hazard cycles -> stall_cnt = 4.
